// File: rtl/map_scroll_arbiter_pkg.sv
// map_pkg: tile codes, default sizes, FSM states and return tag shared by map_scroll_arbiter.
package map_pkg;
    localparam int MAP_LEN    = 87;
    localparam int LANES      = 5;
    localparam int ROW_W      = 7;
    localparam int SCROLL_DIV = 4;
    localparam logic [2:0] TILE_EMPTY = 3'd0;
    localparam logic [2:0] TILE_OBST  = 3'd1;
    localparam logic [2:0] TILE_COIN  = 3'd2;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    typedef enum logic {KIND_RD, KIND_COL} kind_t;
    typedef struct packed {
        kind_t kind;
        logic  oob;
    } tag_t;
endpackage

// File: rtl/map_scroll_arbiter_if.sv
// map_scroll_arbiter_if: renderer read port plus the single map ROM lookup port.
interface map_scroll_arbiter_if #(parameter int ROW_W = map_pkg::ROW_W);
    logic             rd_req;
    logic [2:0]       rd_lane;
    logic [ROW_W-1:0] rd_row_rel;
    logic             rd_grant;
    logic             rd_valid;
    logic [2:0]       rd_state;
    logic [2:0]       map_x;
    logic [ROW_W-1:0] map_y;
    logic [2:0]       map_state;
    modport slave  (input  rd_req, rd_lane, rd_row_rel, map_state,
                    output rd_grant, rd_valid, rd_state, map_x, map_y);
    modport master (output rd_req, rd_lane, rd_row_rel, map_state,
                    input  rd_grant, rd_valid, rd_state, map_x, map_y);
endinterface

// File: rtl/map_scroll_arbiter_timer.sv
// scroll_timer: frame divider and saturating scroll row; o_at_end flags the step onto the last row.
module scroll_timer #(
    parameter int MAP_LEN    = 87,
    parameter int SCROLL_DIV = 4,
    parameter int ROW_W      = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_restart,
    output logic [ROW_W-1:0] o_row,
    output logic             o_at_end
);
    localparam int DIV_W = SCROLL_DIV > 1 ? $clog2(SCROLL_DIV) : 1;
    logic [DIV_W-1:0] r_div;
    logic [ROW_W-1:0] r_row;
    logic             w_wrap;
    assign w_wrap = r_div == DIV_W'(SCROLL_DIV - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_row <= '0;
        end else if (i_restart) begin
            r_div <= '0;
            r_row <= '0;
        end else if (i_en) begin
            r_div <= w_wrap ? '0 : r_div + DIV_W'(1);
            if (w_wrap && r_row != ROW_W'(MAP_LEN - 1))
                r_row <= r_row + ROW_W'(1);
        end
    end
    assign o_row    = r_row;
    assign o_at_end = i_en && w_wrap && r_row == ROW_W'(MAP_LEN - 2);
endmodule

// File: rtl/map_scroll_arbiter.sv
// map_scroll_arbiter: scroll FSM and map-port arbiter (collision check beats renderer reads).
// Define MAP_COIN_MASK_EN to add a collected-coin bitmap that blanks coins once taken.
module map_scroll_arbiter #(
    parameter int MAP_LEN    = map_pkg::MAP_LEN,
    parameter int LANES      = map_pkg::LANES,
    parameter int SCROLL_DIV = map_pkg::SCROLL_DIV,
    parameter int ROW_W      = map_pkg::ROW_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       pause,
    input  logic                       frame_tick,
    input  logic [2:0]                 player_lane,
    map_scroll_arbiter_if.slave        bus,
    output logic [ROW_W-1:0]           scroll_row,
    output logic                       hit_obstacle,
    output logic                       got_coin,
    output logic                       running,
    output logic                       finished
);
    import map_pkg::*;
    state_t           r_state, w_next;
    logic             w_restart, w_tick, w_at_end;
    logic [ROW_W-1:0] w_row;
    logic             r_col_pending;
    logic [2:0]       r_col_lane;
    logic [ROW_W-1:0] r_col_row;
    tag_t             r_tag;
    logic             r_tag_vld;
    logic [ROW_W:0]   w_abs;
    logic             w_rd_oob, w_col_oob, w_masked;
    logic [2:0]       w_ret;

    assign w_tick = r_state == RUN && !pause && frame_tick;

    scroll_timer #(.MAP_LEN(MAP_LEN), .SCROLL_DIV(SCROLL_DIV), .ROW_W(ROW_W)) u_timer (
        .clk(clk), .rst_n(rst_n), .i_en(w_tick), .i_restart(w_restart),
        .o_row(w_row), .o_at_end(w_at_end)
    );

    always_comb begin
        w_next    = r_state;
        w_restart = 1'b0;
        case (r_state)
            IDLE, DONE: if (start) begin
                w_next    = RUN;
                w_restart = 1'b1;
            end
            RUN:     w_next = pause ? PAUSE : (w_at_end ? DONE : RUN);
            PAUSE:   w_next = pause ? PAUSE : RUN;
            default: w_next = IDLE;
        endcase
    end

    // Row sum is one bit wider so rows past the map end are caught instead of wrapping.
    assign w_abs     = {1'b0, w_row} + {1'b0, bus.rd_row_rel};
    assign w_rd_oob  = bus.rd_lane >= 3'(LANES) || w_abs >= (ROW_W + 1)'(MAP_LEN);
    assign w_col_oob = r_col_lane >= 3'(LANES);
    assign bus.rd_grant = bus.rd_req && !r_col_pending;
    assign bus.map_x = r_col_pending ? r_col_lane : bus.rd_lane;
    assign bus.map_y = r_col_pending ? (w_col_oob ? '0 : r_col_row)
                                     : (w_rd_oob ? '0 : w_abs[ROW_W-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_col_pending <= 1'b0;
            r_col_lane    <= '0;
            r_col_row     <= '0;
            r_tag_vld     <= 1'b0;
            r_tag         <= '0;
        end else begin
            r_state       <= w_next;
            r_col_pending <= w_tick;
            if (w_tick) begin
                r_col_lane <= player_lane;
                r_col_row  <= w_row;
            end
            r_tag_vld <= r_col_pending || bus.rd_req;
            r_tag     <= r_col_pending ? tag_t'{kind: KIND_COL, oob: w_col_oob}
                                       : tag_t'{kind: KIND_RD,  oob: w_rd_oob};
        end
    end

`ifdef MAP_COIN_MASK_EN
    logic [LANES-1:0][MAP_LEN-1:0] r_coin;
    logic [2:0]                    r_ret_lane;
    logic [ROW_W-1:0]              r_ret_row;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coin     <= '0;
            r_ret_lane <= '0;
            r_ret_row  <= '0;
        end else begin
            r_ret_lane <= bus.map_x;
            r_ret_row  <= bus.map_y;
            if (w_restart)
                r_coin <= '0;
            else if (got_coin)
                r_coin[r_ret_lane][r_ret_row] <= 1'b1;
        end
    end
    assign w_masked = !r_tag.oob && r_coin[r_ret_lane][r_ret_row];
`else
    assign w_masked = 1'b0;
`endif

    assign w_ret        = (r_tag.oob || w_masked) ? TILE_EMPTY : bus.map_state;
    assign bus.rd_valid = r_tag_vld && r_tag.kind == KIND_RD;
    assign bus.rd_state = bus.rd_valid ? w_ret : TILE_EMPTY;
    assign hit_obstacle = r_tag_vld && r_tag.kind == KIND_COL && w_ret == TILE_OBST;
    assign got_coin     = r_tag_vld && r_tag.kind == KIND_COL && w_ret == TILE_COIN;
    assign scroll_row   = w_row;
    assign running      = r_state == RUN || r_state == PAUSE;
    assign finished     = r_state == DONE;
endmodule

// File: tb/tb_map_scroll_arbiter.sv
// tb_map_scroll_arbiter: randomized + directed stimulus, frame-count reference model, queued scoreboard.
module tb_map_scroll_arbiter;
    localparam int ML = 87;
    localparam int NL = 5;
    localparam int SD = 4;

    logic       clk = 0, rst_n = 0, start = 0, pause = 0, frame_tick = 0;
    logic [2:0] player_lane = 0;
    logic [6:0] scroll_row;
    logic       hit_obstacle, got_coin, running, finished;

    map_scroll_arbiter_if #(.ROW_W(7)) bus();

    map_scroll_arbiter #(.MAP_LEN(ML), .LANES(NL), .SCROLL_DIV(SD), .ROW_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .frame_tick(frame_tick),
        .player_lane(player_lane), .bus(bus.slave), .scroll_row(scroll_row),
        .hit_obstacle(hit_obstacle), .got_coin(got_coin), .running(running), .finished(finished)
    );

    always #5 clk = ~clk;

    // Map ROM stand-in: out-of-range lanes return an obstacle so forcing to 0 is visible.
    logic [2:0] rom [NL][ML];
    always @(posedge clk)
        bus.map_state <= (bus.map_x < 3'(NL) && bus.map_y < 7'(ML)) ? rom[bus.map_x][bus.map_y] : 3'd1;

    int checks = 0, errors = 0;
    int rd_q[$];
    int col_q[$];
    int m_fsm = 0, m_ticks = 0, m_cl = 0, m_cr = 0;
    bit m_pend = 0;
    bit exp_grant = 0, exp_addr = 0;
    int exp_mx = 0, exp_my = 0;
`ifdef MAP_COIN_MASK_EN
    bit m_mask [NL][ML];
`endif

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_row();
        return (m_ticks / SD > ML - 1) ? ML - 1 : m_ticks / SD;
    endfunction

    function automatic int look(int lane, int row);
        if (lane >= NL || row >= ML) return 0;
`ifdef MAP_COIN_MASK_EN
        if (m_mask[lane][row]) return 0;
`endif
        return int'(rom[lane][row]);
    endfunction

    task automatic restart();
        m_ticks = 0;
`ifdef MAP_COIN_MASK_EN
        foreach (m_mask[l, r]) m_mask[l][r] = 0;
`endif
    endtask

    task automatic cyc(bit s, bit p, bit t, int pl, bit rq, int rl, int rel);
        int st, abs_r;
        exp_addr  = 0;
        exp_grant = rq && !m_pend;
        if (m_pend) begin
            st = look(m_cl, m_cr);
            exp_addr = 1; exp_mx = m_cl; exp_my = m_cl >= NL ? 0 : m_cr;
            if (st == 1 || st == 2) col_q.push_back(st);
`ifdef MAP_COIN_MASK_EN
            if (st == 2) m_mask[m_cl][m_cr] = 1;
`endif
        end else if (rq) begin
            abs_r = m_row() + rel;
            exp_addr = 1; exp_mx = rl; exp_my = (rl >= NL || abs_r >= ML) ? 0 : abs_r;
            rd_q.push_back(look(rl, abs_r));
        end
        start = s; pause = p; frame_tick = t; player_lane = 3'(pl);
        bus.rd_req = rq; bus.rd_lane = 3'(rl); bus.rd_row_rel = 7'(rel);
        @(posedge clk); #1;
        m_pend = 0;
        case (m_fsm)
            0, 3: if (s) begin m_fsm = 1; restart(); end
            1: if (p) m_fsm = 2;
               else if (t) begin
                   m_cl = pl; m_cr = m_row(); m_pend = 1; m_ticks++;
                   if (m_row() == ML - 1) m_fsm = 3;
               end
            default: if (!p) m_fsm = 1;
        endcase
    endtask

    task automatic ticks(int n, int pl, bit rq, int rl, int rel);
        repeat (n) begin
            cyc(0, 0, 1, pl, rq, rl, rel);
            repeat (3) cyc(0, 0, 0, pl, rq, rl, rel);
        end
    endtask

    task automatic do_reset();
        rst_n = 0; start = 0; pause = 0; frame_tick = 0; bus.rd_req = 0;
        exp_grant = 0; exp_addr = 0; m_fsm = 0; m_pend = 0; restart();
        rd_q.delete(); col_q.delete();
        #1;
        chk("rst_rd_valid", bus.rd_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hit", hit_obstacle, 0);
        chk("rst_coin", got_coin, 0);
        chk("rst_rd_state", bus.rd_state, 0);
        rst_n = 1;
    endtask

    always @(negedge clk) begin
        chk("rd_grant", bus.rd_grant, exp_grant);
        if (exp_addr) begin
            chk("map_x", bus.map_x, exp_mx);
            chk("map_y", bus.map_y, exp_my);
        end
        chk("scroll_row", scroll_row, m_row());
        chk("running", running, m_fsm == 1 || m_fsm == 2);
        chk("finished", finished, m_fsm == 3);
        if (bus.rd_valid) begin
            chk("rd_valid_expected", rd_q.size() > 0, 1);
            if (rd_q.size() > 0) chk("rd_state", bus.rd_state, rd_q.pop_front());
        end
        if (hit_obstacle || got_coin) begin
            chk("pulse_expected", col_q.size() > 0, 1);
            if (col_q.size() > 0) chk("col_result", int'(hit_obstacle) + 2 * int'(got_coin), col_q.pop_front());
        end
    end

    initial begin
        bit p = 0;
        int rl;
        bus.rd_req = 0; bus.rd_lane = 0; bus.rd_row_rel = 0;
        foreach (rom[l, r]) rom[l][r] = 3'($urandom_range(0, 2));
        rom[0][2] = 3'd2; rom[1][13] = 3'd1; rom[0][53] = 3'd2;
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 2);
        ticks(8, 0, 0, 0, 0);
        chk("row_after_8", scroll_row, 2);
        ticks(44, 0, 0, 0, 0);
        ticks(1, 1, 1, 2, 5);
        cyc(0, 0, 0, 0, 1, 5, 0);
        cyc(0, 0, 0, 0, 1, 0, 77);
        ticks(40, 0, 1, 0, 0);
        repeat (10) begin
            cyc(0, 1, 1, 0, 1, 0, 0);
            repeat (3) cyc(0, 1, 0, 0, 1, 0, 0);
        end
        for (int i = 0; i < 400 && m_fsm != 3; i++) ticks(1, 0, 1, 0, 0);
        chk("done_row", scroll_row, ML - 1);
        ticks(3, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("restart_row", scroll_row, 0);
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 40) == 0) p = !p;
            rl = $urandom_range(0, 9) < 8 ? $urandom_range(0, 4) : $urandom_range(5, 7);
            cyc($urandom_range(0, 400) == 0, p, !m_pend && $urandom_range(0, 2) == 0,
                $urandom_range(0, 7), $urandom_range(0, 3) != 0, rl, $urandom_range(0, 100));
        end
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("col_q_drained", col_q.size(), 0);
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 3);
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        rom[1][0] = 3'd1;
        cyc(0, 0, 1, 1, 0, 0, 0);
        do_reset();
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
        chk("rd_q_final", rd_q.size(), 0);
        chk("col_q_final", col_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
